hex_display_ctrl: RTL

Memory-mapped, parametrised seven-segment display peripheral for the lab CPU system. The CPU writes a value register and a control register over the memory bus; the block drives `NDIGITS` active-low hex digits with registered outputs. Adds leading-zero blanking, a blink mode driven by an internal timebase, a global display enable and register read-back.

---
 rtl/hex_display_pkg.sv | 41 ++++
 rtl/hex_to_sseg.sv | 13 +
 rtl/hex_display_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display peripheral: register map, CTRL bit
// layout and the active-low seven-segment font (bit 0 = segment a).
package hex_display_pkg;

    localparam int OFF_VALUE = 0;
    localparam int OFF_CTRL  = 1;

    localparam int CTRL_W    = 3;
    localparam int LZB_BIT   = 0;
    localparam int BLINK_BIT = 1;
    localparam int EN_BIT    = 2;
    localparam logic [CTRL_W-1:0] CTRL_RST = 3'b100;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_VALUE,
        SEL_CTRL
    } reg_sel_e;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_sseg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_FONT[nibble];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped seven-segment controller: VALUE/CTRL registers, leading-zero
// blanking, blink timebase, global enable and registered segment outputs.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 9'h100,
    parameter int                BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [7*(DATA_W/4)-1:0] segs
);

    localparam int NDIGITS = DATA_W / 4;
    localparam int CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_VALUE = BASE_ADDR + ADDR_W'(OFF_VALUE);
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = BASE_ADDR + ADDR_W'(OFF_CTRL);

    logic [DATA_W-1:0]      value_q, value_d;
    logic [CTRL_W-1:0]      ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]       tick_q,  tick_d;
    logic                   phase_q, phase_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [7*NDIGITS-1:0]   segs_q,  segs_d;

    reg_sel_e               sel;
    logic [NDIGITS-1:0][6:0] font;
    logic [NDIGITS-1:0]     lit;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_dec
        hex_to_sseg u_dec (
            .nibble (value_q[4*g +: 4]),
            .segs   (font[g])
        );
    end

    always_comb begin
        sel = SEL_NONE;
        if (addr == ADDR_VALUE) begin
            sel = SEL_VALUE;
        end else if (addr == ADDR_CTRL) begin
            sel = SEL_CTRL;
        end
    end

    // Digit k stays lit if it or any higher nibble is non-zero; digit 0 always lit.
    always_comb begin
        logic        seen;
        int unsigned k;
        seen = 1'b0;
        lit  = '0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            k      = NDIGITS - 1 - i;
            seen   = seen | (|value_q[4*k +: 4]);
            lit[k] = seen | (k == 0);
        end
    end

    always_comb begin
        value_d = value_q;
        ctrl_d  = ctrl_q;
        rdata_d = '0;
        tick_d  = tick_q + CNT_W'(1);
        phase_d = phase_q;

        if (wr_en && sel == SEL_VALUE) begin
            value_d = wdata;
        end
        if (wr_en && sel == SEL_CTRL) begin
            ctrl_d = wdata[CTRL_W-1:0];
        end

        if (rd_en && sel == SEL_VALUE) begin
            rdata_d = value_q;
        end else if (rd_en && sel == SEL_CTRL) begin
            rdata_d = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
        end

        if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            phase_d = ~phase_q;
        end
        // A CTRL write restarts the blink in its visible phase, even on a wrap edge.
        if (wr_en && sel == SEL_CTRL) begin
            tick_d  = '0;
            phase_d = 1'b0;
        end

        segs_d = '1;
        for (int unsigned d = 0; d < NDIGITS; d++) begin
            if (!ctrl_q[EN_BIT]) begin
                segs_d[7*d +: 7] = SEG_BLANK;
            end else if (ctrl_q[BLINK_BIT] && phase_q) begin
                segs_d[7*d +: 7] = SEG_BLANK;
            end else if (ctrl_q[LZB_BIT] && !lit[d]) begin
                segs_d[7*d +: 7] = SEG_BLANK;
            end else begin
                segs_d[7*d +: 7] = font[d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            ctrl_q  <= CTRL_RST;
            tick_q  <= '0;
            phase_q <= 1'b0;
            rdata_q <= '0;
            segs_q  <= '1;
        end else begin
            value_q <= value_d;
            ctrl_q  <= ctrl_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            rdata_q <= rdata_d;
            segs_q  <= segs_d;
        end
    end

    assign rdata = rdata_q;
    assign segs  = segs_q;

endmodule
